// File: rtl/vote_pkg.sv
// Shared types and helpers for the vote collector slice.
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam int unsigned NUM_VOTERS_DEF = 4;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational population count of the ballot vector.
module vote_popcount #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 3
) (
    input  logic [N-1:0]  bits_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/vote_collector.sv
// Ballot collector: valid/ready intake, duplicate/range rejection, majority/tie result.
// Optional forced close after TIMEOUT_CYCLES in COLLECT when VOTE_TIMEOUT_EN is defined.
module vote_collector
    import vote_pkg::*;
#(
    parameter int unsigned NUM_VOTERS     = NUM_VOTERS_DEF,
    parameter int unsigned ID_W           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  vote_valid,
    input  logic [ID_W-1:0]       vote_id,
    input  logic                  vote_val,
    output logic                  vote_ready,
    output logic                  dup_err,
    output logic                  busy,
    output logic [NUM_VOTERS-1:0] votes,
    output logic [NUM_VOTERS-1:0] voted_mask,
    output logic                  result_valid,
    output logic                  result,
    output logic                  tie,
    input  logic                  result_ack
`ifdef VOTE_TIMEOUT_EN
    ,
    output logic                  timed_out
`endif
);

    localparam int unsigned CW = cnt_width(NUM_VOTERS);

    if (NUM_VOTERS < 2 || NUM_VOTERS > 16 || (1 << ID_W) < NUM_VOTERS || TIMEOUT_CYCLES == 0)
    begin : g_bad_params
        $error("vote_collector: illegal parameter combination");
    end

    state_e                state_q, state_d;
    logic [NUM_VOTERS-1:0] votes_q, votes_d, mask_q, mask_d, sel;
    logic                  dup_q, dup_d, result_q, result_d, tie_q, tie_d;
    logic                  out_of_range, timeout_hit;
    logic [CW-1:0]         yes;

`ifdef VOTE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;
`endif

    // Popcount sees the next-state vector so result/tie register on the DONE entry edge.
    vote_popcount #(
        .N  (NUM_VOTERS),
        .CW (CW)
    ) u_popcount (
        .bits_i  (votes_d),
        .count_o (yes)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_VOTERS; i++) begin
            sel[i] = (vote_id == ID_W'(i));
        end
    end

    assign out_of_range = (32'(vote_id) >= NUM_VOTERS);

`ifdef VOTE_TIMEOUT_EN
    assign timeout_hit = (state_q == COLLECT) && ((cnt_q + 1'b1) == TW'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        votes_d  = votes_q;
        mask_d   = mask_q;
        dup_d    = 1'b0;
        result_d = result_q;
        tie_d    = tie_q;
`ifdef VOTE_TIMEOUT_EN
        cnt_d    = cnt_q;
        to_d     = to_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COLLECT;
                    votes_d = '0;
                    mask_d  = '0;
`ifdef VOTE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            COLLECT: begin
`ifdef VOTE_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (vote_valid) begin
                    if (out_of_range || |(sel & mask_q)) begin
                        dup_d = 1'b1;
                    end else begin
                        votes_d = (votes_q & ~sel) | (sel & {NUM_VOTERS{vote_val}});
                        mask_d  = mask_q | sel;
                    end
                end
                if (&mask_d || timeout_hit) begin
                    state_d  = DONE;
                    result_d = ({yes, 1'b0} >  (CW + 1)'(NUM_VOTERS));
                    tie_d    = ({yes, 1'b0} == (CW + 1)'(NUM_VOTERS));
`ifdef VOTE_TIMEOUT_EN
                    to_d     = ~&mask_d;
`endif
                end
            end
            DONE: begin
                if (result_ack) begin
                    state_d  = IDLE;
                    result_d = 1'b0;
                    tie_d    = 1'b0;
`ifdef VOTE_TIMEOUT_EN
                    to_d     = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            votes_q  <= '0;
            mask_q   <= '0;
            dup_q    <= 1'b0;
            result_q <= 1'b0;
            tie_q    <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
            cnt_q    <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            votes_q  <= votes_d;
            mask_q   <= mask_d;
            dup_q    <= dup_d;
            result_q <= result_d;
            tie_q    <= tie_d;
`ifdef VOTE_TIMEOUT_EN
            cnt_q    <= cnt_d;
            to_q     <= to_d;
`endif
        end
    end

    assign vote_ready   = (state_q == COLLECT);
    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign dup_err      = dup_q;
    assign votes        = votes_q;
    assign voted_mask   = mask_q;
    assign result       = result_q;
    assign tie          = tie_q;
`ifdef VOTE_TIMEOUT_EN
    assign timed_out    = to_q;
`endif

endmodule

// File: tb/tb_vote_collector.sv
// Directed table-driven bench for vote_collector (timeout case runs when VOTE_TIMEOUT_EN is defined).
module tb_vote_collector;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       start = 1'b0, vote_valid = 1'b0, vote_val = 1'b0, result_ack = 1'b0;
    logic [3:0] vote_id = '0;
    logic       vote_ready, dup_err, busy, result_valid, result, tie;
    logic [3:0] votes, voted_mask;
`ifdef VOTE_TIMEOUT_EN
    logic       timed_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       st, vv;
        logic [3:0] id;
        logic       val, ack;
        logic       rdy, dup, bz;
        logic [3:0] mask, vts;
        logic       rv, res, ti;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    vote_collector #(
        .NUM_VOTERS     (4),
        .ID_W           (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vote_valid   (vote_valid),
        .vote_id      (vote_id),
        .vote_val     (vote_val),
        .vote_ready   (vote_ready),
        .dup_err      (dup_err),
        .busy         (busy),
        .votes        (votes),
        .voted_mask   (voted_mask),
        .result_valid (result_valid),
        .result       (result),
        .tie          (tie),
        .result_ack   (result_ack)
`ifdef VOTE_TIMEOUT_EN
        ,
        .timed_out    (timed_out)
`endif
    );

    // Observation order: ready, dup, busy, mask[3:0], votes[3:0], rvalid, result, tie
    function automatic logic [13:0] obs();
        return {vote_ready, dup_err, busy, voted_mask, votes, result_valid, result, tie};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic vv, input logic [3:0] id, input logic val,
                       input logic ack, input logic rdy, input logic dup, input logic bz,
                       input logic [3:0] mask, input logic [3:0] vts, input logic rv,
                       input logic res, input logic ti);
        vec_t v;
        v.st = st; v.vv = vv; v.id = id; v.val = val; v.ack = ack;
        v.rdy = rdy; v.dup = dup; v.bz = bz; v.mask = mask; v.vts = vts;
        v.rv = rv; v.res = res; v.ti = ti;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic st, input logic vv, input logic [3:0] id,
                         input logic val, input logic ack);
        start = st; vote_valid = vv; vote_id = id; vote_val = val; result_ack = ack;
        @(posedge clk);
        #1;
        start = 1'b0; vote_valid = 1'b0; vote_id = '0; vote_val = 1'b0; result_ack = 1'b0;
    endtask

    initial begin
        //   st vv id     val ack | rdy dup bz  mask     votes    rv res tie
        // majority, duplicate, out-of-range, start ignored in COLLECT
        add(T, F, 4'd0, F, F,   T, F, T, 4'b0000, 4'b0000, F, F, F);
        add(F, T, 4'd0, T, F,   T, F, T, 4'b0001, 4'b0001, F, F, F);
        add(F, T, 4'd1, T, F,   T, F, T, 4'b0011, 4'b0011, F, F, F);
        add(F, T, 4'd1, F, F,   T, T, T, 4'b0011, 4'b0011, F, F, F);
        add(F, T, 4'd5, T, F,   T, T, T, 4'b0011, 4'b0011, F, F, F);
        add(F, T, 4'd2, T, F,   T, F, T, 4'b0111, 4'b0111, F, F, F);
        add(T, F, 4'd0, F, F,   T, F, T, 4'b0111, 4'b0111, F, F, F);
        add(F, T, 4'd3, F, F,   F, F, T, 4'b1111, 4'b0111, T, T, F);
        add(F, F, 4'd0, F, T,   F, F, F, 4'b1111, 4'b0111, F, F, F);
        // tie, out-of-order ids; start+ack in DONE; stray inputs in IDLE
        add(T, F, 4'd0, F, F,   T, F, T, 4'b0000, 4'b0000, F, F, F);
        add(F, T, 4'd3, T, F,   T, F, T, 4'b1000, 4'b1000, F, F, F);
        add(F, T, 4'd0, F, F,   T, F, T, 4'b1001, 4'b1000, F, F, F);
        add(F, T, 4'd2, T, F,   T, F, T, 4'b1101, 4'b1100, F, F, F);
        add(F, T, 4'd1, F, F,   F, F, T, 4'b1111, 4'b1100, T, F, T);
        add(T, F, 4'd0, F, T,   F, F, F, 4'b1111, 4'b1100, F, F, F);
        add(F, F, 4'd0, F, F,   F, F, F, 4'b1111, 4'b1100, F, F, F);
        add(F, T, 4'd0, T, F,   F, F, F, 4'b1111, 4'b1100, F, F, F);
        add(F, F, 4'd0, F, T,   F, F, F, 4'b1111, 4'b1100, F, F, F);

        #1;
        chk("reset_state", 16'(obs()), 16'h0000);
        #21;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_idle", 16'(obs()), 16'h0000);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].vv, tbl[i].id, tbl[i].val, tbl[i].ack);
            chk($sformatf("vec%0d", i), 16'(obs()),
                16'({tbl[i].rdy, tbl[i].dup, tbl[i].bz, tbl[i].mask, tbl[i].vts,
                     tbl[i].rv, tbl[i].res, tbl[i].ti}));
        end

        // Hold in DONE while start/vote_valid are asserted without ack
        drive(T, F, 4'd0, F, F);
        for (int i = 0; i < 4; i++) drive(F, T, 4'(i), T, F);
        chk("done_all_yes", 16'(obs()), 16'(14'b0_0_1_1111_1111_1_1_0));
        for (int i = 0; i < 10; i++) begin
            drive(T, T, 4'(i % 4), F, F);
            chk($sformatf("done_hold%0d", i), 16'(obs()), 16'(14'b0_0_1_1111_1111_1_1_0));
        end
        drive(T, F, 4'd0, F, T);
        chk("start_ack_to_idle", 16'(obs()), 16'(14'b0_0_0_1111_1111_0_0_0));
        drive(F, F, 4'd0, F, F);
        chk("start_not_remembered", 16'(busy), 16'h0000);

        // Asynchronous reset mid-COLLECT with two ballots in
        drive(T, F, 4'd0, F, F);
        drive(F, T, 4'd0, T, F);
        drive(F, T, 4'd1, F, F);
        chk("pre_reset_mask", 16'(voted_mask), 16'h0003);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_clear", 16'(obs()), 16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_busy_ready", 16'({busy, vote_ready}), 16'h0000);

`ifdef VOTE_TIMEOUT_EN
        // Forced close after 8 COLLECT cycles with only voters 0 and 1 in
        drive(T, F, 4'd0, F, F);
        drive(F, T, 4'd0, T, F);
        drive(F, T, 4'd1, T, F);
        for (int i = 0; i < 5; i++) drive(F, F, 4'd0, F, F);
        chk("timeout_not_yet", 16'(result_valid), 16'h0000);
        drive(F, F, 4'd0, F, F);
        chk("timeout_done", 16'(obs()), 16'(14'b0_0_1_0011_0011_1_0_1));
        chk("timed_out_set", 16'(timed_out), 16'h0001);
        drive(F, F, 4'd0, F, T);
        chk("timed_out_clear", 16'({timed_out, busy}), 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
